// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: shared widths and Wallace-tree row counts for the ALU multiply path
package alu_mul_pkg;
    localparam int MUL_W      = 32;
    localparam int PROD_W     = 64;
    localparam int MUL_STAGES = 3;
    localparam int CSA_LEVELS = 8;
    localparam int S1_LEVELS  = 4;
    // Rows entering each CSA level; the last entry is the sum/carry pair.
    localparam int LVL_ROWS [0:8] = '{33, 22, 15, 10, 7, 5, 4, 3, 2};
endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: row of full adders compressing three vectors into sum and shifted carry
module csa_3to2 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    assign sum   = x ^ y ^ z;
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;
endmodule

// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: 3-stage pipelined Wallace-tree multiplier with valid/ready on both sides
module wallace_mul_pipe
    import alu_mul_pkg::*;
#(
    parameter int WIDTH     = MUL_W,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW   = 2 * WIDTH;
    localparam int MAXR = LVL_ROWS[0];
    localparam int S1R  = LVL_ROWS[S1_LEVELS];

    logic            sgn, adv, v1, v2, v3;
    logic [PW-1:0]   ax;
    logic [PW-1:0]   t [0:CSA_LEVELS-1][0:MAXR-1];
    logic [PW-1:0]   o [0:CSA_LEVELS-1][0:MAXR-1];
    logic [PW-1:0]   s1_row [0:S1R-1];
    logic [PW-1:0]   s2_sum, s2_carry;

    assign sgn       = SIGNED_EN & is_signed;
    assign ax        = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    assign adv       = !v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // Signed mode inverts the top row and adds 2^(WIDTH-1) to negate b's sign weight.
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp
        assign t[0][j] = b[j] ? ((sgn && j == WIDTH - 1) ? ~ax : ax) << j : '0;
    end
    assign t[0][WIDTH] = (sgn & b[WIDTH-1]) ? PW'(1) << (WIDTH - 1) : '0;

    for (genvar l = 0; l < CSA_LEVELS; l++) begin : g_lvl
        localparam int N = LVL_ROWS[l];
        localparam int K = N / 3;
        localparam int R = N % 3;
        localparam int M = LVL_ROWS[l+1];
        for (genvar i = 0; i < K; i++) begin : g_csa
            csa_3to2 #(.WIDTH(PW)) u_csa (
                .x     (t[l][3*i]),
                .y     (t[l][3*i+1]),
                .z     (t[l][3*i+2]),
                .sum   (o[l][2*i]),
                .carry (o[l][2*i+1])
            );
        end
        for (genvar i = 0; i < R; i++) begin : g_pass
            assign o[l][2*K+i] = t[l][3*K+i];
        end
        for (genvar i = M; i < MAXR; i++) begin : g_zero
            assign o[l][i] = '0;
        end
    end

    // Level S1_LEVELS is fed from the S1 register rather than combinationally.
    for (genvar l = 1; l < CSA_LEVELS; l++) begin : g_link
        for (genvar j = 0; j < MAXR; j++) begin : g_row
            if (l == S1_LEVELS && j < S1R) begin : g_reg
                assign t[l][j] = s1_row[j];
            end else if (l == S1_LEVELS) begin : g_nil
                assign t[l][j] = '0;
            end else begin : g_comb
                assign t[l][j] = o[l-1][j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_row   <= '{default: '0};
            s2_sum   <= '0;
            s2_carry <= '0;
            product  <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            for (int i = 0; i < S1R; i++) s1_row[i] <= o[S1_LEVELS-1][i];
            s2_sum   <= o[CSA_LEVELS-1][0];
            s2_carry <= o[CSA_LEVELS-1][1];
            if (v2) product <= s2_sum + s2_carry;
        end
    end
endmodule
